control_sequencer: RTL and testbench

- Hardwired Moore control unit that drives every control input of the CPU datapath: register in/out enables, select/encode strobes, memory read/write, I/O port enables and ALU register loads.
- Runs the fetch/decode/execute step sequence for each instruction, reading the opcode from the IR value the datapath exports.
- Sits beside the datapath at CPU top level; the datapath responds, this block initiates.

---
 rtl/control_sequencer_if.sv | 34 +++
 rtl/control_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bundle between the control sequencer and the CPU datapath.
// The datapath exports the IR value, the CON flag and the stop request.
// The sequencer drives every control input of the datapath.
// Modports:
//   master - the sequencer: reads ir/con/stop and drives all control strobes
//   slave  - the datapath: drives ir/con/stop and reads all control strobes
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con;
    logic        stop;

    logic pci, pco, iri, iro, mari, mdri, mdro;
    logic mem_read, mem_write;
    logic hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo;
    logic opi, ipi, ipo, csigno;
    logic gra, grb, grc, rin, rout, baout;
    logic con_in, incpc, run;

    modport master (
        input  ir, con, stop,
        output pci, pco, iri, iro, mari, mdri, mdro, mem_read, mem_write,
               hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo,
               opi, ipi, ipo, csigno, gra, grb, grc, rin, rout, baout,
               con_in, incpc, run
    );

    modport slave (
        output ir, con, stop,
        input  pci, pco, iri, iro, mari, mdri, mdro, mem_read, mem_write,
               hii, hio, loi, loo, ryi, rzhi, rzli, rzho, rzlo,
               opi, ipi, ipo, csigno, gra, grb, grc, rin, rout, baout,
               con_in, incpc, run
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the CPU datapath.
// It sequences fetch (F0-F2) and the execute steps T3-T7 of each instruction class.
// Every control strobe is decoded from the current state and the wait counter.
// Ports:
//   clock - rising-edge system clock
//   clear - synchronous active-high reset (to RST)
//   bus   - control_sequencer_if.master: ir/con/stop in, all datapath strobes out
module control_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter logic [4:0]  HALT_OP  = 5'b11010
) (
    input  logic                   clock,
    input  logic                   clear,
    control_sequencer_if.master    bus
);

    typedef enum logic [3:0] {
        S_RST, S_F0, S_F1, S_F2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_IMM, C_MD, C_NEG, C_BR,
        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
    } cls_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    // HALT_OP is tested first so a relocated halt opcode overrides its class.
    function automatic cls_t decode_cls(input logic [4:0] op);
        cls_t c;
        if (op == HALT_OP) begin
            c = C_HALT;
        end else begin
            case (op) inside
                5'b00000:             c = C_LD;
                5'b00001:             c = C_LDI;
                5'b00010:             c = C_ST;
                [5'b00011:5'b01010]:  c = C_ALU;
                [5'b01011:5'b01101]:  c = C_IMM;
                [5'b01110:5'b01111]:  c = C_MD;
                [5'b10000:5'b10001]:  c = C_NEG;
                5'b10010:             c = C_BR;
                5'b10011:             c = C_JR;
                5'b10101:             c = C_IN;
                5'b10110:             c = C_OUT;
                5'b10111:             c = C_MFHI;
                5'b11000:             c = C_MFLO;
                default:              c = C_NOP;
            endcase
        end
        return c;
    endfunction

    state_t     r_state;
    logic [3:0] r_wait;
    cls_t       r_cls;

    cls_t       w_cls_ir;
    cls_t       w_cls;
    state_t     w_end;
    logic       w_wait_done;
    logic       w_unused_ir;

    assign w_cls_ir    = decode_cls(bus.ir[31:27]);
    // The IR is only valid from T3 on, so T3 decodes it live and later steps use the latched class.
    assign w_cls       = (r_state == S_T3) ? w_cls_ir : r_cls;
    assign w_end       = bus.stop ? S_HALT : S_F0;
    assign w_wait_done = (r_wait == 4'd0);
    assign w_unused_ir = ^bus.ir[26:0];

    // State register, wait counter and latched instruction class.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_RST;
            r_wait  <= 4'd0;
            r_cls   <= C_NOP;
        end else begin
            case (r_state)
                S_RST:  r_state <= S_F0;
                S_F0: begin
                    r_state <= S_F1;
                    r_wait  <= WAIT_LOAD;
                end
                S_F1: begin
                    if (w_wait_done) r_state <= S_F2;
                    else             r_wait  <= r_wait - 4'd1;
                end
                S_F2:   r_state <= S_T3;
                S_T3: begin
                    r_cls <= w_cls_ir;
                    case (w_cls_ir)
                        C_HALT:                                 r_state <= S_HALT;
                        C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP: r_state <= w_end;
                        default:                                r_state <= S_T4;
                    endcase
                end
                S_T4: begin
                    if (r_cls == C_NEG) r_state <= w_end;
                    else                r_state <= S_T5;
                end
                S_T5: begin
                    case (r_cls)
                        C_LD, C_ST, C_MD, C_BR: begin
                            r_state <= S_T6;
                            r_wait  <= WAIT_LOAD;
                        end
                        default: r_state <= w_end;
                    endcase
                end
                S_T6: begin
                    case (r_cls)
                        C_LD: begin
                            if (w_wait_done) r_state <= S_T7;
                            else             r_wait  <= r_wait - 4'd1;
                        end
                        C_ST: begin
                            r_state <= S_T7;
                            r_wait  <= WAIT_LOAD;
                        end
                        default: r_state <= w_end;
                    endcase
                end
                S_T7: begin
                    if ((r_cls == C_ST) && !w_wait_done) r_wait  <= r_wait - 4'd1;
                    else                                 r_state <= w_end;
                end
                S_HALT: r_state <= S_HALT;
                default: begin
                    r_state <= S_RST;
                    r_wait  <= 4'd0;
                end
            endcase
        end
    end

    // Moore output decode from state, latched class and wait counter.
    always_comb begin
        bus.pci = 1'b0; bus.pco = 1'b0; bus.iri = 1'b0; bus.iro = 1'b0;
        bus.mari = 1'b0; bus.mdri = 1'b0; bus.mdro = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.hii = 1'b0; bus.hio = 1'b0; bus.loi = 1'b0; bus.loo = 1'b0;
        bus.ryi = 1'b0; bus.rzhi = 1'b0; bus.rzli = 1'b0; bus.rzho = 1'b0; bus.rzlo = 1'b0;
        bus.opi = 1'b0; bus.ipi = 1'b0; bus.ipo = 1'b0; bus.csigno = 1'b0;
        bus.gra = 1'b0; bus.grb = 1'b0; bus.grc = 1'b0;
        bus.rin = 1'b0; bus.rout = 1'b0; bus.baout = 1'b0;
        bus.con_in = 1'b0; bus.incpc = 1'b0;
        bus.run = (r_state != S_RST) && (r_state != S_HALT);
        case (r_state)
            S_F0: begin bus.pco = 1'b1; bus.mari = 1'b1; bus.incpc = 1'b1; end
            S_F1: begin bus.mem_read = 1'b1; bus.mdri = w_wait_done; end
            S_F2: begin bus.mdro = 1'b1; bus.iri = 1'b1; end
            S_T3: begin
                case (w_cls)
                    C_LD, C_LDI, C_ST: begin bus.grb = 1'b1; bus.baout = 1'b1; bus.ryi = 1'b1; end
                    C_ALU, C_IMM:      begin bus.grb = 1'b1; bus.rout = 1'b1; bus.ryi = 1'b1; end
                    C_MD:              begin bus.gra = 1'b1; bus.rout = 1'b1; bus.ryi = 1'b1; end
                    C_NEG:             begin bus.grb = 1'b1; bus.rout = 1'b1; bus.rzli = 1'b1; end
                    C_BR:              begin bus.gra = 1'b1; bus.rout = 1'b1; bus.con_in = 1'b1; end
                    C_JR:              begin bus.gra = 1'b1; bus.rout = 1'b1; bus.pci = 1'b1; end
                    C_IN:              begin bus.ipo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                    C_OUT:             begin bus.gra = 1'b1; bus.rout = 1'b1; bus.opi = 1'b1; end
                    C_MFHI:            begin bus.hio = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                    C_MFLO:            begin bus.loo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                    default:           begin end
                endcase
            end
            S_T4: begin
                case (w_cls)
                    C_LD, C_LDI, C_ST, C_IMM, C_BR: begin bus.csigno = 1'b1; bus.rzli = 1'b1; end
                    C_ALU: begin bus.grc = 1'b1; bus.rout = 1'b1; bus.rzli = 1'b1; end
                    C_MD:  begin bus.grb = 1'b1; bus.rout = 1'b1; bus.rzhi = 1'b1; bus.rzli = 1'b1; end
                    C_NEG: begin bus.rzlo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                    default: begin end
                endcase
                // Branch T4 is overridden: PC goes to Y ahead of the offset add.
                if (w_cls == C_BR) begin
                    bus.csigno = 1'b0; bus.rzli = 1'b0; bus.pco = 1'b1; bus.ryi = 1'b1;
                end else begin
                    bus.pco = 1'b0;
                end
            end
            S_T5: begin
                case (w_cls)
                    C_LD, C_ST:           begin bus.rzlo = 1'b1; bus.mari = 1'b1; end
                    C_LDI, C_ALU, C_IMM:  begin bus.rzlo = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                    C_MD:                 begin bus.rzlo = 1'b1; bus.loi = 1'b1; end
                    C_BR:                 begin bus.csigno = 1'b1; bus.rzli = 1'b1; end
                    default:              begin end
                endcase
            end
            S_T6: begin
                case (w_cls)
                    C_LD: begin bus.mem_read = 1'b1; bus.mdri = w_wait_done; end
                    C_ST: begin bus.gra = 1'b1; bus.rout = 1'b1; bus.mdri = 1'b1; end
                    C_MD: begin bus.rzho = 1'b1; bus.hii = 1'b1; end
                    // Branch target reaches the PC only when the condition holds.
                    C_BR: begin bus.rzlo = bus.con; bus.pci = bus.con; end
                    default: begin end
                endcase
            end
            S_T7: begin
                case (w_cls)
                    C_LD: begin bus.mdro = 1'b1; bus.gra = 1'b1; bus.rin = 1'b1; end
                    C_ST: begin bus.mem_write = 1'b1; end
                    default: begin end
                endcase
            end
            default: begin end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] ir    = 32'h0;
    logic        con   = 1'b0;
    logic        stop  = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clock = ~clock;

    control_sequencer_if if1 ();
    control_sequencer_if if3 ();

    assign if1.ir = ir;  assign if1.con = con;  assign if1.stop = stop;
    assign if3.ir = ir;  assign if3.con = con;  assign if3.stop = stop;

    control_sequencer #(.MEM_WAIT(1), .HALT_OP(5'b11010)) dut1 (.clock(clock), .clear(clear), .bus(if1));
    control_sequencer #(.MEM_WAIT(3), .HALT_OP(5'b11010)) dut3 (.clock(clock), .clear(clear), .bus(if3));

    // Bit positions of the packed observation vector.
    localparam logic [30:0] PCI    = 31'd1 << 0;
    localparam logic [30:0] PCO    = 31'd1 << 1;
    localparam logic [30:0] IRI    = 31'd1 << 2;
    localparam logic [30:0] MARI   = 31'd1 << 4;
    localparam logic [30:0] MDRI   = 31'd1 << 5;
    localparam logic [30:0] MDRO   = 31'd1 << 6;
    localparam logic [30:0] MR     = 31'd1 << 7;
    localparam logic [30:0] MW     = 31'd1 << 8;
    localparam logic [30:0] HII    = 31'd1 << 9;
    localparam logic [30:0] LOI    = 31'd1 << 11;
    localparam logic [30:0] RYI    = 31'd1 << 13;
    localparam logic [30:0] RZHI   = 31'd1 << 14;
    localparam logic [30:0] RZLI   = 31'd1 << 15;
    localparam logic [30:0] RZHO   = 31'd1 << 16;
    localparam logic [30:0] RZLO   = 31'd1 << 17;
    localparam logic [30:0] CSIGNO = 31'd1 << 21;
    localparam logic [30:0] GRA    = 31'd1 << 22;
    localparam logic [30:0] GRB    = 31'd1 << 23;
    localparam logic [30:0] GRC    = 31'd1 << 24;
    localparam logic [30:0] RIN    = 31'd1 << 25;
    localparam logic [30:0] ROUT   = 31'd1 << 26;
    localparam logic [30:0] BAOUT  = 31'd1 << 27;
    localparam logic [30:0] CON_IN = 31'd1 << 28;
    localparam logic [30:0] INCPC  = 31'd1 << 29;
    localparam logic [30:0] RUN    = 31'd1 << 30;

    localparam logic [30:0] E_F0 = RUN | PCO | MARI | INCPC;
    localparam logic [30:0] E_F2 = RUN | MDRO | IRI;

    logic [30:0] o1, o3;
    assign o1 = {if1.run, if1.incpc, if1.con_in, if1.baout, if1.rout, if1.rin, if1.grc, if1.grb,
                 if1.gra, if1.csigno, if1.ipo, if1.ipi, if1.opi, if1.rzlo, if1.rzho, if1.rzli,
                 if1.rzhi, if1.ryi, if1.loo, if1.loi, if1.hio, if1.hii, if1.mem_write, if1.mem_read,
                 if1.mdro, if1.mdri, if1.mari, if1.iro, if1.iri, if1.pco, if1.pci};
    assign o3 = {if3.run, if3.incpc, if3.con_in, if3.baout, if3.rout, if3.rin, if3.grc, if3.grb,
                 if3.gra, if3.csigno, if3.ipo, if3.ipi, if3.opi, if3.rzlo, if3.rzho, if3.rzli,
                 if3.rzhi, if3.ryi, if3.loo, if3.loi, if3.hio, if3.hii, if3.mem_write, if3.mem_read,
                 if3.mdro, if3.mdri, if3.mari, if3.iro, if3.iri, if3.pco, if3.pci};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    // Safety properties: one bus driver, no read+write, ipi never driven.
    function automatic logic [2:0] safety(input logic [30:0] o);
        logic [9:0] drv;
        drv = {o[1], o[3], o[6], o[10], o[12], o[16], o[17], o[20], o[21], o[26] | o[27]};
        return {($countones(drv) <= 1), !(o[7] & o[8]), !o[19]};
    endfunction

    // Clear for one sampled edge; the next tick shows F0.
    task automatic restart(input logic [31:0] new_ir, input logic new_con, input logic new_stop);
        ir = new_ir; con = new_con; stop = new_stop;
        clear = 1'b1;
        tick();
        chk("rst_cycle", {1'b0, o1}, 32'h0);
        clear = 1'b0;
    endtask

    logic [30:0] exp_q[$];

    task automatic run_seq(input string tag, input bit use3);
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            if (use3) chk($sformatf("%s_%0d", tag, i), {1'b0, o3}, {1'b0, exp_q[i]});
            else      chk($sformatf("%s_%0d", tag, i), {1'b0, o1}, {1'b0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    initial begin
        logic prev_clear;
        logic [4:0] rop;

        // Reset held for two edges: everything low, run low.
        ir = 32'h18908000;
        clear = 1'b1;
        repeat (2) @(posedge clock);
        tick();
        chk("reset_o1", {1'b0, o1}, 32'h0);
        chk("reset_o3", {1'b0, o3}, 32'h0);
        clear = 1'b0;

        // add: fetch then reg ALU steps, back to F0 on cycle 7.
        exp_q = '{E_F0, RUN | MR | MDRI, E_F2,
                  RUN | GRB | ROUT | RYI, RUN | GRC | ROUT | RZLI, RUN | RZLO | GRA | RIN, E_F0};
        run_seq("add", 1'b0);

        // ld with three-cycle memory access on fetch and on T6.
        restart(32'h0000_0000, 1'b0, 1'b0);
        exp_q = '{E_F0, RUN | MR, RUN | MR, RUN | MR | MDRI, E_F2,
                  RUN | GRB | BAOUT | RYI, RUN | CSIGNO | RZLI, RUN | RZLO | MARI,
                  RUN | MR, RUN | MR, RUN | MR | MDRI, RUN | MDRO | GRA | RIN, E_F0};
        run_seq("ld3", 1'b1);

        // st with three-cycle write on T7.
        restart(32'h1000_0000, 1'b0, 1'b0);
        exp_q = '{E_F0, RUN | MR, RUN | MR, RUN | MR | MDRI, E_F2,
                  RUN | GRB | BAOUT | RYI, RUN | CSIGNO | RZLI, RUN | RZLO | MARI,
                  RUN | GRA | ROUT | MDRI, RUN | MW, RUN | MW, RUN | MW, E_F0};
        run_seq("st3", 1'b1);

        // br not taken, then taken.
        restart(32'h9000_0000, 1'b0, 1'b0);
        exp_q = '{E_F0, RUN | MR | MDRI, E_F2, RUN | GRA | ROUT | CON_IN, RUN | PCO | RYI,
                  RUN | CSIGNO | RZLI, RUN, E_F0};
        run_seq("br0", 1'b0);
        restart(32'h9000_0000, 1'b1, 1'b0);
        exp_q = '{E_F0, RUN | MR | MDRI, E_F2, RUN | GRA | ROUT | CON_IN, RUN | PCO | RYI,
                  RUN | CSIGNO | RZLI, RUN | RZLO | PCI, E_F0};
        run_seq("br1", 1'b0);

        // mul.
        restart(32'h7000_0000, 1'b0, 1'b0);
        exp_q = '{E_F0, RUN | MR | MDRI, E_F2, RUN | GRA | ROUT | RYI,
                  RUN | GRB | ROUT | RZHI | RZLI, RUN | RZLO | LOI, RUN | RZHO | HII, E_F0};
        run_seq("mul", 1'b0);

        // stop during add: HALT after T5.
        restart(32'h18908000, 1'b0, 1'b1);
        exp_q = '{E_F0, RUN | MR | MDRI, E_F2, RUN | GRB | ROUT | RYI,
                  RUN | GRC | ROUT | RZLI, RUN | RZLO | GRA | RIN, 31'd0, 31'd0};
        run_seq("stop", 1'b0);

        // HALT opcode: HALT after T3, stays quiet for 20 cycles.
        restart(32'hD000_0000, 1'b0, 1'b0);
        exp_q = '{E_F0, RUN | MR | MDRI, E_F2, RUN};
        for (int i = 0; i < 20; i++) exp_q.push_back(31'd0);
        run_seq("halt", 1'b0);

        // Random opcodes with random clear pulses.
        prev_clear = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            chk("safe1", {29'd0, safety(o1)}, 32'd7);
            chk("safe3", {29'd0, safety(o3)}, 32'd7);
            if (prev_clear) begin
                chk("clr_rst1", {1'b0, o1}, 32'h0);
                chk("clr_rst3", {1'b0, o3}, 32'h0);
            end
            rop   = 5'($urandom_range(0, 31));
            ir    = {rop, 27'($urandom())};
            con   = 1'($urandom_range(0, 1));
            stop  = ($urandom_range(0, 63) == 0);
            clear = ($urandom_range(0, 24) == 0);
            prev_clear = clear;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
